// File: rtl/aes_pkg.sv
// aes_pkg: shared constants, types and GF(2^8) helpers for the AES
// byte-substitution datapath.
//   AES_BLOCK_BYTES  bytes in one AES state
//   SBOX_AFFINE_C    constant of the forward S-box affine map
//   INV_AFFINE_C     constant of the inverse affine map
//   GF_RED_POLY      low byte of x^8+x^4+x^3+x+1
//   rotl8            8-bit rotate left
//   gf_mul8          GF(2^8) multiply modulo the AES polynomial
//   inv_affine8      inverse affine map applied before the field inverse
//   fwd_affine8      forward affine map applied after the field inverse
//   fsm_state_e      engine FSM encoding
package aes_pkg;

  localparam int         AES_BLOCK_BYTES = 16;
  localparam logic [7:0] SBOX_AFFINE_C   = 8'h63;
  localparam logic [7:0] INV_AFFINE_C    = 8'h05;
  localparam logic [7:0] GF_RED_POLY     = 8'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_state_e;

  // Rotate left by n (0..7) one bit position at a time.
  function automatic logic [7:0] rotl8(input logic [7:0] b, input int unsigned n);
    logic [7:0] r;
    r = b;
    for (int i = 0; i < 8; i++) begin
      if (i < int'(n)) r = {r[6:0], r[7]};
      else             r = r;
    end
    return r;
  endfunction

  // Shift-and-add multiply, reducing whenever the running multiplicand overflows.
  function automatic logic [7:0] gf_mul8(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      else      acc = acc;
      if (aa[7]) aa = {aa[6:0], 1'b0} ^ GF_RED_POLY;
      else       aa = {aa[6:0], 1'b0};
    end
    return acc;
  endfunction

  function automatic logic [7:0] inv_affine8(input logic [7:0] b);
    return rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ INV_AFFINE_C;
  endfunction

  function automatic logic [7:0] fwd_affine8(input logic [7:0] b);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ SBOX_AFFINE_C;
  endfunction

endpackage

// File: rtl/gf256_inv.sv
// gf256_inv: combinational multiplicative inverse in GF(2^8), computed as
// a^254 with a fixed square/multiply chain. Zero maps to zero naturally.
//   a  in  8  field element
//   y  out 8  a^-1 (0 for a == 0)
import aes_pkg::*;

module gf256_inv (
  input  logic [7:0] a,
  output logic [7:0] y
);

  logic [7:0] p3_s, p7_s, p15_s, p31_s, p63_s, p127_s;

  // Exponent chain: each step squares then multiplies by a, adding one bit of 1s.
  always_comb begin
    p3_s   = gf_mul8(gf_mul8(a, a), a);
    p7_s   = gf_mul8(gf_mul8(p3_s, p3_s), a);
    p15_s  = gf_mul8(gf_mul8(p7_s, p7_s), a);
    p31_s  = gf_mul8(gf_mul8(p15_s, p15_s), a);
    p63_s  = gf_mul8(gf_mul8(p31_s, p31_s), a);
    p127_s = gf_mul8(gf_mul8(p63_s, p63_s), a);
    y      = gf_mul8(p127_s, p127_s);
  end

endmodule

// File: rtl/aes_inv_sub_bytes.sv
// aes_inv_sub_bytes: lane-serial InvSubBytes engine for a 128-bit AES state.
// LANES bytes are substituted per cycle, so a block takes N = 16/LANES cycles.
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake, accept only in IDLE
//   in_state              input state, byte i = in_state[8i+7:8i]
//   out_valid/out_ready   output handshake, result held in DONE
//   out_state             substituted state
//   busy                  high while a block is in RUN or DONE
// Optional macro AES_SUB_BYTES_FWD_EN adds input 'encrypt' (sampled at accept);
// when set, lanes compute forward SubBytes using the same field inverters.
import aes_pkg::*;

module aes_inv_sub_bytes #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
`ifdef AES_SUB_BYTES_FWD_EN
  input  logic         encrypt,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int N     = AES_BLOCK_BYTES / LANES;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  fsm_state_e       fsm_q, fsm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [127:0]     blk_q, blk_d;
`ifdef AES_SUB_BYTES_FWD_EN
  logic             enc_q, enc_d;
`endif

  logic [7:0] lane_in_s  [LANES];
  logic [7:0] gf_in_s    [LANES];
  logic [7:0] gf_out_s   [LANES];
  logic [7:0] lane_out_s [LANES];

  // Lane input select and pre-inverse transform (inverse affine, or bypass for encrypt).
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_in_s[l] = blk_q[(int'(cnt_q) * LANES + l) * 8 +: 8];
`ifdef AES_SUB_BYTES_FWD_EN
      if (enc_q) gf_in_s[l] = lane_in_s[l];
      else       gf_in_s[l] = inv_affine8(lane_in_s[l]);
`else
      gf_in_s[l] = inv_affine8(lane_in_s[l]);
`endif
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    gf256_inv u_inv (
      .a (gf_in_s[g]),
      .y (gf_out_s[g])
    );
  end

  // Post-inverse transform: forward affine only for encrypt, else the inverse is the result.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
`ifdef AES_SUB_BYTES_FWD_EN
      if (enc_q) lane_out_s[l] = fwd_affine8(gf_out_s[l]);
      else       lane_out_s[l] = gf_out_s[l];
`else
      lane_out_s[l] = gf_out_s[l];
`endif
    end
  end

  // Next-state logic: accept in IDLE, substitute one lane group per RUN cycle, hold in DONE.
  always_comb begin
    fsm_d = fsm_q;
    cnt_d = cnt_q;
    blk_d = blk_q;
`ifdef AES_SUB_BYTES_FWD_EN
    enc_d = enc_q;
`endif
    case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          fsm_d = RUN;
          cnt_d = {CNT_W{1'b0}};
          blk_d = in_state;
`ifdef AES_SUB_BYTES_FWD_EN
          enc_d = encrypt;
`endif
        end else begin
          fsm_d = IDLE;
        end
      end
      RUN: begin
        for (int l = 0; l < LANES; l++) begin
          blk_d[(int'(cnt_q) * LANES + l) * 8 +: 8] = lane_out_s[l];
        end
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) fsm_d = DONE;
        else                   fsm_d = RUN;
      end
      DONE: begin
        if (out_ready) fsm_d = IDLE;
        else           fsm_d = DONE;
      end
      default: begin
        fsm_d = IDLE;
        cnt_d = {CNT_W{1'b0}};
      end
    endcase
  end

  // State register with asynchronous reset discarding any in-flight block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q <= IDLE;
      cnt_q <= {CNT_W{1'b0}};
      blk_q <= 128'h0;
`ifdef AES_SUB_BYTES_FWD_EN
      enc_q <= 1'b0;
`endif
    end else begin
      fsm_q <= fsm_d;
      cnt_q <= cnt_d;
      blk_q <= blk_d;
`ifdef AES_SUB_BYTES_FWD_EN
      enc_q <= enc_d;
`endif
    end
  end

  // Outputs decode directly from registered state, so they are glitch-free.
  always_comb begin
    in_ready  = (fsm_q == IDLE);
    out_valid = (fsm_q == DONE);
    busy      = (fsm_q == RUN) || (fsm_q == DONE);
    out_state = blk_q;
  end

endmodule
